// File: rtl/or_reduce_acc_pkg.sv
// Shared types and constants for the OR-reduce/accumulate block.
// The beat word is sized for the widest supported channel word; narrower instances zero-extend.
package or_pkg;

  localparam logic MODE_PASS  = 1'b0;
  localparam logic MODE_ACCUM = 1'b1;

  localparam int OR_MAX_W = 64;

  typedef struct packed {
    logic [OR_MAX_W-1:0] word;
    logic                mode;
  } or_beat_t;

endpackage

// File: rtl/or_reduce_acc_if.sv
// Input beat / output result handshake bundle for or_reduce_acc, plus clear and hit counter.
interface or_reduce_acc_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int COUNT_W  = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      in_mode;
  logic                      clear;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_word;
  logic                      out_any;
  logic [COUNT_W-1:0]        hit_count;

  modport master (
    output in_valid, in_data, in_mode, clear, out_ready,
    input  in_ready, out_valid, out_word, out_any, hit_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, clear, out_ready,
    output in_ready, out_valid, out_word, out_any, hit_count
  );

endinterface

// File: rtl/or_reduce_acc_pipe_slice.sv
// One valid/ready register slice: loads when empty or when the consumer takes the current entry,
// and holds valid and payload stable while stalled.
module or_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/or_reduce_acc.sv
// Two-stage OR reduction across CHANNELS words with per-beat PASS/ACCUM mode,
// sticky accumulator and saturating count of non-zero results.
module or_reduce_acc
  import or_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int COUNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  or_reduce_acc_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             any;
  } res_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  if (WIDTH > OR_MAX_W) begin : g_width_chk
    $error("or_reduce_acc: WIDTH exceeds or_pkg::OR_MAX_W");
  end
  if (CHANNELS < 2) begin : g_chan_chk
    $error("or_reduce_acc: CHANNELS must be at least 2");
  end

  logic [WIDTH-1:0] ch_word [CHANNELS];
  logic [WIDTH-1:0] or_p0;
  or_beat_t         beat_p0;
  or_beat_t         beat_p1;
  logic             vld_p1;
  logic             rdy_p1;
  logic             rdy_p2;
  logic [WIDTH-1:0] word_p1;
  logic             accum_p1;
  logic             adv_p1;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_upd;
  res_t             res_nxt;
  res_t             res_p2;
  logic             vld_p2;
  logic [COUNT_W-1:0] hit_q;
  logic             unused_hi;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign ch_word[c] = bus.in_data[c*WIDTH +: WIDTH];
  end

  always_comb begin
    or_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      or_p0 = or_p0 | ch_word[c];
    end
  end

  always_comb begin
    beat_p0      = '0;
    beat_p0.word = OR_MAX_W'(or_p0);
    beat_p0.mode = bus.in_mode;
  end

  // ---- S1: channel OR + mode ----
  or_pipe_slice #(.W($bits(or_beat_t))) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (bus.in_valid),
    .in_rdy   (rdy_p1),
    .in_data  (beat_p0),
    .out_vld  (vld_p1),
    .out_rdy  (rdy_p2),
    .out_data (beat_p1)
  );

  assign bus.in_ready = rdy_p1;
  assign word_p1      = beat_p1.word[WIDTH-1:0];
  assign unused_hi    = |(beat_p1.word >> WIDTH);
  assign accum_p1     = (beat_p1.mode == MODE_ACCUM);
  assign adv_p1       = vld_p1 && rdy_p2;

  // clear only discards what the accumulator held before this edge
  assign acc_upd = (bus.clear ? '0 : acc) | word_p1;

  always_comb begin
    res_nxt      = '0;
    res_nxt.word = accum_p1 ? acc_upd : word_p1;
    res_nxt.any  = |res_nxt.word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (adv_p1 && accum_p1) begin
      acc <= acc_upd;
    end else if (bus.clear) begin
      acc <= '0;
    end
  end

  // ---- S2: result / accumulator view ----
  or_pipe_slice #(.W($bits(res_t))) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (vld_p1),
    .in_rdy   (rdy_p2),
    .in_data  (res_nxt),
    .out_vld  (vld_p2),
    .out_rdy  (bus.out_ready),
    .out_data (res_p2)
  );

  assign bus.out_valid = vld_p2;
  assign bus.out_word  = res_p2.word;
  assign bus.out_any   = res_p2.any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (bus.clear) begin
      hit_q <= '0;
    end else if (vld_p2 && bus.out_ready && res_p2.any) begin
      hit_q <= sat_inc(hit_q);
    end
  end

  assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_or_reduce_acc.sv
// Directed bench for or_reduce_acc: vector table for PASS/ACCUM/clear, plus backpressure,
// mid-stream reset and hit counter saturation sequences.
module tb_or_reduce_acc;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  or_reduce_acc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .COUNT_W(8)) bus ();
  or_reduce_acc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .COUNT_W(2)) sbus ();

  or_reduce_acc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .COUNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  or_reduce_acc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .COUNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  typedef struct {
    logic [127:0] data;
    logic         mode;
    logic         clr;
    logic         clr_late;
    logic [15:0]  exp_word;
    logic         exp_any;
    logic [7:0]   exp_hit;
  } vec_t;

  vec_t vecs [16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One beat end to end: accept edge, S1->S2 edge, output transfer edge.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.in_mode  = v.mode;
    bus.clear    = v.clr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = v.clr_late;
    chk($sformatf("v%0d_early_valid", idx), 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.clear = 1'b0;
    chk($sformatf("v%0d_valid", idx), 32'(bus.out_valid), 32'd1);
    chk($sformatf("v%0d_word", idx), 32'(bus.out_word), 32'(v.exp_word));
    chk($sformatf("v%0d_any", idx), 32'(bus.out_any), 32'(v.exp_any));
    @(negedge clk);
    chk($sformatf("v%0d_hit", idx), 32'(bus.hit_count), 32'(v.exp_hit));
    chk($sformatf("v%0d_drained", idx), 32'(bus.out_valid), 32'd0);
  endtask

  logic [127:0] bp_data [4];
  logic [15:0]  bp_exp  [4];
  logic [15:0]  held_word;
  int           sent;
  int           got;
  logic [1:0]   sat_exp [5];

  initial begin
    vecs[0]  = '{{16'h8000, 80'h0, 16'h0010, 16'h0001}, 1'b0, 1'b0, 1'b0, 16'h8011, 1'b1, 8'd1};
    vecs[1]  = '{128'h0,                                1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd1};
    vecs[2]  = '{128'h0001,                             1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 8'd2};
    vecs[3]  = '{{32'h0, 16'h0100, 80'h0},              1'b1, 1'b0, 1'b0, 16'h0101, 1'b1, 8'd3};
    vecs[4]  = '{128'h0001,                             1'b1, 1'b0, 1'b0, 16'h0101, 1'b1, 8'd4};
    vecs[5]  = '{128'h0002,                             1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 8'd1};
    vecs[6]  = '{128'h0001,                             1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 8'd2};
    vecs[7]  = '{128'h00F0,                             1'b0, 1'b0, 1'b0, 16'h00F0, 1'b1, 8'd3};
    vecs[8]  = '{{16'h0004, 64'h0, 16'h0004, 32'h0},    1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 8'd4};
    vecs[9]  = '{128'h0001,                             1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 8'd1};
    vecs[10] = '{128'h00F0,                             1'b0, 1'b0, 1'b0, 16'h00F0, 1'b1, 8'd2};
    vecs[11] = '{128'h0002,                             1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 8'd3};
    vecs[12] = '{128'h0040,                             1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 8'd1};
    vecs[13] = '{128'h0,                                1'b1, 1'b0, 1'b0, 16'h0040, 1'b1, 8'd2};
    vecs[14] = '{128'h4000_1000_0400_0100_0040_0010_0004_0001,
                                                        1'b0, 1'b0, 1'b0, 16'h5555, 1'b1, 8'd3};
    vecs[15] = '{128'h0,                                1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd3};

    bp_data[0] = 128'h1111;                        bp_exp[0] = 16'h1111;
    bp_data[1] = {64'h0, 16'h2222, 48'h0};         bp_exp[1] = 16'h2222;
    bp_data[2] = {16'h0, 16'h0030, 64'h0, 16'h0300, 16'h0};
                                                   bp_exp[2] = 16'h0330;
    bp_data[3] = {16'h4444, 112'h0};               bp_exp[3] = 16'h4444;

    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_mode  = 1'b0; bus.clear  = 1'b0; bus.out_ready  = 1'b1;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_mode = 1'b0; sbus.clear = 1'b0; sbus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_word", 32'(bus.out_word), 32'd0);
    chk("rst_out_any", 32'(bus.out_any), 32'd0);
    chk("rst_hit", 32'(bus.hit_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: four beats offered while the output is stalled for five cycles
    sent = 0;
    got  = 0;
    held_word = 16'h0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (sent < 4);
      bus.in_mode   = 1'b0;
      bus.in_data   = (sent < 4) ? bp_data[sent] : '0;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), 32'(bus.in_ready), 32'd0);
        chk($sformatf("bp_accepted_c%0d", cyc), 32'(sent), 32'd2);
        chk($sformatf("bp_hold_valid_c%0d", cyc), 32'(bus.out_valid), 32'd1);
        chk($sformatf("bp_hold_word_c%0d", cyc), 32'(bus.out_word), 32'(bp_exp[0]));
      end
      if (bus.in_valid && bus.in_ready) begin
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_order_%0d", got), 32'(bus.out_word), 32'(bp_exp[got]));
        got++;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_all_results", 32'(got), 32'd4);
    @(negedge clk);
    chk("bp_no_duplicate", 32'(bus.out_valid), 32'd0);
    chk("bp_hit", 32'(bus.hit_count), 32'd7);

    // Mid-stream reset with both stages full and the output stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 1'b1;
    bus.in_data   = 128'h0F00;
    @(negedge clk);
    bus.in_data   = 128'h00F0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_word", 32'(bus.out_word), 32'd0);
    chk("mid_rst_any", 32'(bus.out_any), 32'd0);
    chk("mid_rst_hit", 32'(bus.hit_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = 1'b1;
    bus.in_data  = 128'h0A0A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_rst_n1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_word", 32'(bus.out_word), 32'h0A0A);
    @(negedge clk);
    chk("post_rst_hit", 32'(bus.hit_count), 32'd1);
    chk("post_rst_drained", 32'(bus.out_valid), 32'd0);

    // Saturating hit counter on the COUNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sbus.in_valid = 1'b1;
      sbus.in_data  = {80'h0, 16'(i + 1), 32'h0};
      @(negedge clk);
      sbus.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("sat%0d_word", i), 32'(sbus.out_word), 32'(i + 1));
      @(negedge clk);
      chk($sformatf("sat%0d_hit", i), 32'(sbus.hit_count), 32'(sat_exp[i]));
    end
    @(negedge clk);
    sbus.in_valid = 1'b1;
    sbus.in_data  = 128'h00FF;
    @(negedge clk);
    sbus.in_valid = 1'b0;
    @(negedge clk);
    sbus.clear = 1'b1;
    chk("sat_clr_valid", 32'(sbus.out_valid), 32'd1);
    chk("sat_clr_word", 32'(sbus.out_word), 32'h00FF);
    @(negedge clk);
    sbus.clear = 1'b0;
    chk("sat_clr_hit", 32'(sbus.hit_count), 32'd0);
    chk("sat_clr_drained", 32'(sbus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
